// File: rtl/round_robin_mux_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : round_robin_mux_arbiter_if
// Purpose  : Bundles the requester-side and downstream-side valid/ready
//            signals of the round-robin mux arbiter.
// Ports    : none (signal container)
//            in_valid  [N_INPUTS]        request bit per input
//            in_data   [N_INPUTS*WIDTH]  packed data, input k at [k*WIDTH +: WIDTH]
//            in_ready  [N_INPUTS]        one-hot grant / take strobe
//            out_valid                   output register holds a word
//            out_data  [WIDTH]           registered selected word
//            out_sel   [SEL_W]           registered index of the supplier
//            out_ready                   downstream accepts out_data
// Modports : slave  - the arbiter
//            master - the environment driving requests and consuming output
// Revision : 1.0 - initial release
// ============================================================================
interface round_robin_mux_arbiter_if #(
  parameter int N_INPUTS = 4,
  parameter int WIDTH    = 8
) ();
  localparam int SEL_W = $clog2(N_INPUTS);

  logic [N_INPUTS-1:0]       in_valid;
  logic [N_INPUTS*WIDTH-1:0] in_data;
  logic [N_INPUTS-1:0]       in_ready;
  logic                      out_valid;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_sel;
  logic                      out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );
endinterface
`default_nettype wire

// File: rtl/round_robin_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : round_robin_mux_arbiter
// Purpose  : Registered N-input round-robin arbiter with an internal N:1 data
//            mux. One word per cycle, one-entry output register, and the
//            registered select is exported for reuse downstream.
// Ports    : clk  - clock, all state on rising edge
//            rst  - synchronous active-high reset
//            bus  - round_robin_mux_arbiter_if.slave (valid/ready bus)
// Revision : 1.0 - initial release
// ============================================================================
module round_robin_mux_arbiter #(
  parameter int N_INPUTS = 4,
  parameter int WIDTH    = 8
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  round_robin_mux_arbiter_if.slave   bus
);
  localparam int SEL_W = $clog2(N_INPUTS);

  // Output-register occupancy doubles as the FSM state.
  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [SEL_W-1:0]  r_ptr;
  logic [SEL_W-1:0]  r_sel;
  logic [WIDTH-1:0]  r_data;

  logic              w_load;
  logic              w_found;
  logic              w_fire;
  logic [SEL_W-1:0]  w_grant;
  logic [SEL_W-1:0]  w_ptr_nxt;
  logic [WIDTH-1:0]  w_data;
  logic [WIDTH-1:0]  w_words [N_INPUTS];
  int                w_idx;

  generate
    for (genvar k = 0; k < N_INPUTS; k++) begin : g_unpack
      assign w_words[k] = bus.in_data[k*WIDTH +: WIDTH];
    end
  endgenerate

  assign w_load = (r_state == S_EMPTY) || bus.out_ready;

  // Search order ptr, ptr+1, ..., wrapping by comparison against N_INPUTS so
  // non-power-of-two requester counts never visit a nonexistent index.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = 0;
    for (int i = 0; i < N_INPUTS; i++) begin
      w_idx = int'(r_ptr) + i;
      if (w_idx >= N_INPUTS) begin
        w_idx = w_idx - N_INPUTS;
      end
      if (!w_found && bus.in_valid[SEL_W'(w_idx)]) begin
        w_found = 1'b1;
        w_grant = SEL_W'(w_idx);
      end
    end
  end

  // N:1 data mux driven by the grant index.
  always_comb begin
    w_data = '0;
    for (int k = 0; k < N_INPUTS; k++) begin
      if (w_grant == SEL_W'(k)) begin
        w_data = w_words[k];
      end
    end
  end

  assign w_fire    = w_load && w_found;
  assign w_ptr_nxt = (w_grant == SEL_W'(N_INPUTS - 1)) ? '0 : SEL_W'(w_grant + 1'b1);

  // Grant is suppressed during reset so no word is consumed and then lost.
  assign bus.in_ready = (w_fire && !rst) ? (N_INPUTS'(1) << w_grant) : '0;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: begin
        if (w_found) begin
          w_state_nxt = S_FULL;
        end
      end
      S_FULL: begin
        if (bus.out_ready) begin
          w_state_nxt = w_found ? S_FULL : S_EMPTY;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_EMPTY;
      r_ptr   <= '0;
      r_sel   <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_fire) begin
        r_data <= w_data;
        r_sel  <= w_grant;
        r_ptr  <= w_ptr_nxt;
      end
    end
  end

  assign bus.out_valid = (r_state == S_FULL);
  assign bus.out_data  = r_data;
  assign bus.out_sel   = r_sel;

endmodule
`default_nettype wire

// File: doc/round_robin_mux_arbiter.md
# round_robin_mux_arbiter

Registered N-input round-robin arbiter that selects one valid requester per cycle and forwards its data through an internal N:1 mux. Sits directly upstream of the mux-based datapath stages. It produces the mux select (`out_sel`) together with the selected word, so downstream logic can reuse the select. Valid/ready handshake on every port; one-entry output register; sustained throughput of one word per cycle.

## Interface

- `N_INPUTS`, 4, number of requesters; legal range 2..16, not required to be a power of two.
- `WIDTH`, 8, data width of each requester.
- `SEL_W`, `$clog2(N_INPUTS)`, width of select/pointer (derived, not overridden).

Ports:

- `clk` input 1: single clock, all state on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input N_INPUTS: request bit per input.
- `in_data` input N_INPUTS*WIDTH: packed data; input k occupies bits [k*WIDTH +: WIDTH].
- `in_ready` output N_INPUTS: one-hot or zero; the granted input's data is taken this cycle.
- `out_valid` output 1: output register holds a word.
- `out_data` output WIDTH: registered selected word.
- `out_sel` output SEL_W: registered index of the input that supplied `out_data`.
- `out_ready` input 1: downstream accepts `out_data` this cycle.

## Operation

- State: priority pointer `ptr` (SEL_W bits) plus the output register (`out_valid`, `out_data`, `out_sel`).
- Two-state FSM is equivalent to `out_valid`:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- Load condition: `load = !out_valid || out_ready`.
- Grant search: the first k with `in_valid[k]=1` in the order ptr, ptr+1, …, N_INPUTS-1, 0, …, ptr-1. Wrap is by comparison against N_INPUTS-1, not by bit truncation.
- If `load` and any `in_valid`:
  - `in_ready[grant]=1`, all other `in_ready` bits 0.
  - Next edge: `out_data <= in_data[grant]`, `out_sel <= grant`, `out_valid <= 1`.
  - `ptr <= (grant==N_INPUTS-1) ? 0 : grant+1`.
- If `load` and no `in_valid`: `in_ready=0`; next edge `out_valid <= 0`; `out_data`, `out_sel` and `ptr` hold.
- If not `load` (FULL and `out_ready=0`): `in_ready=0`; output register and `ptr` hold.
- Simultaneous drain and fill (FULL, `out_ready=1`, request present): the new word replaces the old on the same edge with no bubble.
- A requester that is not granted keeps its request; fairness bound is N_INPUTS-1 grants to others before it is served.

## Timing

- Reset values (applied at the edge where `rst=1`):
  - `out_valid=0`, `out_data=0`, `out_sel=0`, `ptr=0`.
  - `in_ready` is forced to 0 while `rst=1`.
- Latency: input word accepted at edge t appears on `out_data` with `out_valid=1` after edge t (one cycle).
- `in_ready` is combinational from `in_valid`, `out_valid`, `out_ready` and `ptr`.
- `out_valid`, `out_data` and `out_sel` are purely registered, with no combinational input-to-output path.
- While `out_valid=1` and `out_ready=0`, `out_data` and `out_sel` are stable.
- Reset mid-transfer discards the held word and any in-flight grant. The first grant after reset goes to the lowest valid index.

## Test plan

- **Reset:** `rst=1` for 2 cycles with `in_valid=4'b1111` -> `in_ready=0`, `out_valid=0`, `out_sel=0`, `out_data=0`.
- **Full-load rotation:** `in_valid=4'b1111`, data 0xA0/0xB1/0xC2/0xD3, `out_ready=1` -> grants 0,1,2,3,0,1 on consecutive cycles. `out_data` shows 0xA0,0xB1,0xC2,0xD3,0xA0 one cycle later; `out_valid` stays 1.
- **Backpressure:** after `out_data=0xB1` appears, hold `out_ready=0` for 3 cycles -> `in_ready=0`, `out_data=0xB1` and `out_sel=1` held. Release -> next word 0xC2 with no bubble.
- **Sparse wrap:** with `ptr=3`, only `in_valid[2]=1` -> grant 2, `out_sel=2`, `ptr` becomes 3. With no requests the next cycle, `out_valid` drops to 0.
- **Mid-stream reset:** assert `rst` for 1 cycle while `out_valid=1` and `ptr=2` with all inputs requesting -> next cycle `out_valid=0`. First grant after reset is input 0.
- **N_INPUTS=3:** all valid, `out_ready=1` -> grants 0,1,2,0,1; `ptr` never takes value 3.
